// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : IF/MEM arbiter for a shared fixed-latency single-port memory
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              mem_r_en_i,
    input  logic              mem_w_en_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ready_o,
    output logic              freeze_o,
    output logic              sram_en_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic [DATA_W-1:0] sram_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] C_LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                grant_q, grant_d;     // 1 = MEM owns the access
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

    logic                w_mem_req;
    logic                w_if_stall;
    logic                w_mem_stall;

    assign w_mem_req = mem_r_en_i | mem_w_en_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            grant_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                // A simultaneous load+store request degrades to a load.
                if (w_mem_req) begin
                    state_d = BUSY;
                    grant_d = 1'b1;
                    we_d    = mem_w_en_i & ~mem_r_en_i;
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                end else if (if_req_i) begin
                    state_d = BUSY;
                    grant_d = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = if_addr_i;
                end
            end
            BUSY: begin
                if (cnt_q == C_LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                    if (!we_q) begin
                        if (grant_q) begin
                            mem_rdata_d = sram_rdata_i;
                        end else begin
                            if_rdata_d = sram_rdata_i;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign sram_en_o    = (state_q == BUSY);
    assign sram_we_o    = (state_q == BUSY) & we_q;
    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = wdata_q;

    assign if_ready_o   = (state_q == DONE) & ~grant_q;
    assign mem_ready_o  = (state_q == DONE) &  grant_q;
    assign if_rdata_o   = if_rdata_q;
    assign mem_rdata_o  = mem_rdata_q;

    // Freeze is forced low while reset is held so every output reads 0.
    assign w_if_stall  = if_req_i  & ~if_ready_o;
    assign w_mem_stall = w_mem_req & ~mem_ready_o;
    assign freeze_o    = rst_n & (w_if_stall | w_mem_stall);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (WAIT_CYCLES=4 and 1) checked every cycle
// against a transaction-phase model, plus hand-computed directed expectations.
`default_nettype none

module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic [31:0] if_rdata  [2];
    logic        if_ready  [2];
    logic        mem_r_en  [2];
    logic        mem_w_en  [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        mem_ready [2];
    logic        freeze    [2];
    logic        sram_en   [2];
    logic        sram_we   [2];
    logic [31:0] sram_addr [2];
    logic [31:0] sram_wdata[2];
    logic [31:0] sram_rdata[2];
    int          en_run    [2];

    int n_chk  = 0;
    int n_pass = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req[0]), .if_addr_i(if_addr[0]), .if_rdata_o(if_rdata[0]), .if_ready_o(if_ready[0]),
        .mem_r_en_i(mem_r_en[0]), .mem_w_en_i(mem_w_en[0]), .mem_addr_i(mem_addr[0]),
        .mem_wdata_i(mem_wdata[0]), .mem_rdata_o(mem_rdata[0]), .mem_ready_o(mem_ready[0]),
        .freeze_o(freeze[0]), .sram_en_o(sram_en[0]), .sram_we_o(sram_we[0]),
        .sram_addr_o(sram_addr[0]), .sram_wdata_o(sram_wdata[0]), .sram_rdata_i(sram_rdata[0])
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req[1]), .if_addr_i(if_addr[1]), .if_rdata_o(if_rdata[1]), .if_ready_o(if_ready[1]),
        .mem_r_en_i(mem_r_en[1]), .mem_w_en_i(mem_w_en[1]), .mem_addr_i(mem_addr[1]),
        .mem_wdata_i(mem_wdata[1]), .mem_rdata_o(mem_rdata[1]), .mem_ready_o(mem_ready[1]),
        .freeze_o(freeze[1]), .sram_en_o(sram_en[1]), .sram_we_o(sram_we[1]),
        .sram_addr_o(sram_addr[1]), .sram_wdata_o(sram_wdata[1]), .sram_rdata_i(sram_rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wc(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    // Memory contents: one fixed instruction word, everything else address-derived.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h10) return 32'hE3A0_0001;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Fixed-latency memory: data only valid in the last cycle of an enable run.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) en_run[k] <= sram_en[k] ? en_run[k] + 1 : 0;
    end
    assign sram_rdata[0] = (sram_en[0] && en_run[0] == 3) ? mem_f(sram_addr[0]) : 32'hBAD0_BAD0;
    assign sram_rdata[1] = (sram_en[1] && en_run[1] == 0) ? mem_f(sram_addr[1]) : 32'hBAD0_BAD0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Model: phase 0 = free, 1..W = memory cycles of the access, W+1 = completion cycle.
    typedef struct {
        int          phase;
        bit          gnt_mem;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] if_data;
        logic [31:0] mem_data;
    } mdl_t;
    mdl_t m [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m[k].phase <= 0;   m[k].gnt_mem <= 1'b0; m[k].we <= 1'b0;
                m[k].addr <= '0;   m[k].wdata <= '0;
                m[k].if_data <= '0; m[k].mem_data <= '0;
            end else if (m[k].phase == 0) begin
                if (mem_r_en[k] || mem_w_en[k]) begin
                    m[k].phase <= 1; m[k].gnt_mem <= 1'b1;
                    m[k].we <= mem_w_en[k] && !mem_r_en[k];
                    m[k].addr <= mem_addr[k]; m[k].wdata <= mem_wdata[k];
                end else if (if_req[k]) begin
                    m[k].phase <= 1; m[k].gnt_mem <= 1'b0; m[k].we <= 1'b0;
                    m[k].addr <= if_addr[k];
                end
            end else if (m[k].phase <= wc(k)) begin
                if (m[k].phase == wc(k) && !m[k].we) begin
                    if (m[k].gnt_mem) m[k].mem_data <= mem_f(m[k].addr);
                    else              m[k].if_data  <= mem_f(m[k].addr);
                end
                m[k].phase <= m[k].phase + 1;
            end else begin
                m[k].phase <= 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit en_e, ifr_e, memr_e, frz_e;
            en_e   = (m[k].phase >= 1) && (m[k].phase <= wc(k));
            ifr_e  = (m[k].phase == wc(k) + 1) && !m[k].gnt_mem;
            memr_e = (m[k].phase == wc(k) + 1) &&  m[k].gnt_mem;
            frz_e  = rst_n && ((if_req[k] && !ifr_e) || ((mem_r_en[k] || mem_w_en[k]) && !memr_e));
            chk($sformatf("i%0d.sram_en", k),   {31'b0, sram_en[k]},   {31'b0, en_e});
            chk($sformatf("i%0d.sram_we", k),   {31'b0, sram_we[k]},   {31'b0, en_e && m[k].we});
            chk($sformatf("i%0d.if_ready", k),  {31'b0, if_ready[k]},  {31'b0, ifr_e});
            chk($sformatf("i%0d.mem_ready", k), {31'b0, mem_ready[k]}, {31'b0, memr_e});
            chk($sformatf("i%0d.freeze", k),    {31'b0, freeze[k]},    {31'b0, frz_e});
            chk($sformatf("i%0d.if_rdata", k),  if_rdata[k],  m[k].if_data);
            chk($sformatf("i%0d.mem_rdata", k), mem_rdata[k], m[k].mem_data);
            if (en_e) chk($sformatf("i%0d.sram_addr", k), sram_addr[k], m[k].addr);
            if (en_e && m[k].we) chk($sformatf("i%0d.sram_wdata", k), sram_wdata[k], m[k].wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the wanted ready pulses on instance k, releasing each request on the
    // edge that ends its pulse. Cycle 1 is the cycle the task starts in.
    task automatic run(input int k, input bit want_if, input bit want_mem, input int max,
                       output int if_at, output int mem_at, output int nen, output int nwe);
        bit got_if, got_mem, drop_if, drop_mem;
        if_at = 0; mem_at = 0; nen = 0; nwe = 0;
        got_if = !want_if; got_mem = !want_mem;
        for (int i = 1; i <= max && !(got_if && got_mem); i++) begin
            @(negedge clk);
            drop_if = 1'b0; drop_mem = 1'b0;
            if (sram_en[k]) nen++;
            if (sram_we[k]) nwe++;
            if (if_ready[k] && !got_if)   begin got_if = 1'b1;  if_at = i;  drop_if = 1'b1;  end
            if (mem_ready[k] && !got_mem) begin got_mem = 1'b1; mem_at = i; drop_mem = 1'b1; end
            tick();
            if (drop_if) if_req[k] = 1'b0;
            if (drop_mem) begin mem_r_en[k] = 1'b0; mem_w_en[k] = 1'b0; end
        end
        chk($sformatf("i%0d.completed", k), {31'b0, got_if && got_mem}, 32'd1);
    endtask

    initial begin
        int if_at, mem_at, nen, nwe, n, pulses;
        int          at_c [3];
        logic [31:0] at_d [3];

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0; mem_r_en[k] = 1'b0; mem_w_en[k] = 1'b0;
            mem_addr[k] = '0; mem_wdata[k] = '0;
        end
        tick(); tick();
        chk("rst.sram_en",   {31'b0, sram_en[0]},  32'd0);
        chk("rst.if_ready",  {31'b0, if_ready[0]}, 32'd0);
        chk("rst.mem_rdata", mem_rdata[0], 32'd0);
        chk("rst.sram_addr", sram_addr[0], 32'd0);
        rst_n = 1'b1;
        tick();

        // Single fetch
        if_addr[0] = 32'h10; if_req[0] = 1'b1;
        #1 chk("fetch.freeze0", {31'b0, freeze[0]}, 32'd1);
        run(0, 1'b1, 1'b0, 20, if_at, mem_at, nen, nwe);
        chk("fetch.if_at", if_at, 32'd6);
        chk("fetch.nen", nen, 32'd4);
        chk("fetch.if_rdata", if_rdata[0], 32'hE3A0_0001);

        // Collision: MEM first, IF next
        if_addr[0] = 32'h20; if_req[0] = 1'b1;
        mem_addr[0] = 32'h500; mem_r_en[0] = 1'b1;
        run(0, 1'b1, 1'b1, 40, if_at, mem_at, nen, nwe);
        chk("coll.mem_at", mem_at, 32'd6);
        chk("coll.if_at", if_at, 32'd12);
        chk("coll.nen", nen, 32'd8);
        chk("coll.mem_rdata", mem_rdata[0], 32'h5F5A_0500);
        chk("coll.if_rdata", if_rdata[0], 32'h5A7A_0020);

        // Store leaves mem_rdata alone
        mem_addr[0] = 32'h400; mem_wdata[0] = 32'hDEAD_BEEF; mem_w_en[0] = 1'b1;
        run(0, 1'b0, 1'b1, 20, if_at, mem_at, nen, nwe);
        chk("store.mem_at", mem_at, 32'd6);
        chk("store.nwe", nwe, 32'd4);
        chk("store.mem_rdata", mem_rdata[0], 32'h5F5A_0500);

        // Withdrawal mid-access, then a normal load
        if_addr[0] = 32'h30; if_req[0] = 1'b1;
        tick(); tick();
        if_req[0] = 1'b0;
        run(0, 1'b1, 1'b0, 20, if_at, mem_at, nen, nwe);
        chk("wdraw.if_at", if_at, 32'd4);
        chk("wdraw.nen", nen, 32'd3);
        chk("wdraw.if_rdata", if_rdata[0], 32'h5A6A_0030);
        mem_addr[0] = 32'h44; mem_r_en[0] = 1'b1;
        run(0, 1'b0, 1'b1, 20, if_at, mem_at, nen, nwe);
        chk("wdraw.mem_at", mem_at, 32'd6);
        chk("wdraw.mem_rdata", mem_rdata[0], 32'h5A1E_0044);

        // Back-to-back fetches on the WAIT_CYCLES=1 instance
        if_addr[1] = 32'h0; if_req[1] = 1'b1;
        n = 0; nen = 0;
        for (int i = 1; i <= 30 && n < 3; i++) begin
            bit seen;
            @(negedge clk);
            seen = 1'b0;
            if (sram_en[1]) nen++;
            if (if_ready[1]) begin at_c[n] = i; at_d[n] = if_rdata[1]; n++; seen = 1'b1; end
            tick();
            if (seen) begin
                if (n < 3) if_addr[1] = 32'(n * 4);
                else       if_req[1] = 1'b0;
            end
        end
        chk("b2b.count", n, 32'd3);
        chk("b2b.nen", nen, 32'd3);
        if (n == 3) begin
            chk("b2b.at0", at_c[0], 32'd3);
            chk("b2b.at1", at_c[1], 32'd6);
            chk("b2b.at2", at_c[2], 32'd9);
            chk("b2b.d0", at_d[0], 32'h5A5A_0000);
            chk("b2b.d1", at_d[1], 32'h5A5E_0004);
            chk("b2b.d2", at_d[2], 32'h5A52_0008);
        end

        // Reset in the middle of a store
        mem_addr[0] = 32'h600; mem_wdata[0] = 32'h1234_5678; mem_w_en[0] = 1'b1;
        tick(); tick();
        #1 chk("mrst.pre_we", {31'b0, sram_we[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst.sram_en",    {31'b0, sram_en[0]},   32'd0);
        chk("mrst.sram_we",    {31'b0, sram_we[0]},   32'd0);
        chk("mrst.sram_addr",  sram_addr[0],  32'd0);
        chk("mrst.sram_wdata", sram_wdata[0], 32'd0);
        chk("mrst.if_rdata",   if_rdata[0],   32'd0);
        chk("mrst.mem_rdata",  mem_rdata[0],  32'd0);
        chk("mrst.mem_ready",  {31'b0, mem_ready[0]}, 32'd0);
        chk("mrst.freeze",     {31'b0, freeze[0]},    32'd0);
        mem_w_en[0] = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_ready[0] || if_ready[0] || sram_en[0]) pulses++;
        end
        chk("mrst.no_activity", pulses, 32'd0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
